// File: rtl/gci_std_display_timing_out.sv
// gci_std_display_timing_out
//
// Display timing generator and pixel output stage (display clock domain).
// Raster counters h/v drive the read stage (oRD_ENA / oRD_SYNC). The decoded
// timing (active, hsync, vsync) is delayed one stage (S1) so it lines up with
// the pixel the read stage returns one clock after the request. Then it is
// registered onto the panel outputs. Total latency from counter position to
// oDISP_* is 2 clocks.
//
// Ports:
//   iDISP_CLOCK       pixel clock
//   inRESET           asynchronous active-low reset
//   iDISP_ENA         scan enable (low = stopped, blanked, read stage in resync)
//   oRD_ENA           pixel request to the read stage
//   oRD_SYNC          resync request (high while stopped, 1-clock pulse at frame end)
//   iRD_VALID         returned pixel valid (1 clock after oRD_ENA)
//   iRD_DATA_R/G/B    returned pixel data
//   oDISP_HSYNC/VSYNC registered syncs, polarity from P_H_SYNC_POL / P_V_SYNC_POL
//   oDISP_DE          registered data enable
//   oDISP_R/G/B       registered pixel data (black outside active or on underflow)
//   oUNDERFLOW        sticky: an active pixel arrived without iRD_VALID
//
// Optional feature, macro GCI_STD_DISP_TEST_PATTERN_EN:
//   adds input iPATTERN_SEL. When it is high, RGB comes from an internal 8-bar
//   colour generator and underflow detection is suppressed.

module gci_std_display_timing_out #(
  parameter int P_H_AREA     = 640,
  parameter int P_H_FRONT    = 16,
  parameter int P_H_SYNC     = 96,
  parameter int P_H_BACK     = 48,
  parameter int P_V_AREA     = 480,
  parameter int P_V_FRONT    = 10,
  parameter int P_V_SYNC     = 2,
  parameter int P_V_BACK     = 33,
  parameter bit P_H_SYNC_POL = 1'b0,
  parameter bit P_V_SYNC_POL = 1'b0,
  parameter int P_CNT_N      = 10
) (
  input  logic       iDISP_CLOCK,
  input  logic       inRESET,
  input  logic       iDISP_ENA,
  output logic       oRD_ENA,
  output logic       oRD_SYNC,
  input  logic       iRD_VALID,
  input  logic [7:0] iRD_DATA_R,
  input  logic [7:0] iRD_DATA_G,
  input  logic [7:0] iRD_DATA_B,
`ifdef GCI_STD_DISP_TEST_PATTERN_EN
  input  logic       iPATTERN_SEL,
`endif
  output logic       oDISP_HSYNC,
  output logic       oDISP_VSYNC,
  output logic       oDISP_DE,
  output logic [7:0] oDISP_R,
  output logic [7:0] oDISP_G,
  output logic [7:0] oDISP_B,
  output logic       oUNDERFLOW
);

  localparam int H_TOTAL = P_H_AREA + P_H_FRONT + P_H_SYNC + P_H_BACK;
  localparam int V_TOTAL = P_V_AREA + P_V_FRONT + P_V_SYNC + P_V_BACK;

  typedef logic [P_CNT_N-1:0] cnt_t;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_AREA_C = cnt_t'(P_H_AREA);
  localparam cnt_t V_AREA_C = cnt_t'(P_V_AREA);
  localparam cnt_t HS_BEG   = cnt_t'(P_H_AREA + P_H_FRONT);
  localparam cnt_t HS_END   = cnt_t'(P_H_AREA + P_H_FRONT + P_H_SYNC);
  localparam cnt_t VS_BEG   = cnt_t'(P_V_AREA + P_V_FRONT);
  localparam cnt_t VS_END   = cnt_t'(P_V_AREA + P_V_FRONT + P_V_SYNC);

  // Timing decode carried down the alignment pipeline
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } tim_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  logic b_run;
  cnt_t h, v;
  tim_t s0, s1;
  rgb_t rd_pix, pix_next;
  logic uf_evt;

  // ---------------------------------------------------------------------------
  // Run flag and raster counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_run <= 1'b0;
      h     <= '0;
      v     <= '0;
    end else begin
      b_run <= iDISP_ENA;
      if (!b_run) begin
        h <= '0;
        v <= '0;
      end else if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S0 decode. Gated by b_run because the stopped counters sit at 0,0, which
  // would otherwise decode as an active pixel.
  // ---------------------------------------------------------------------------
  always_comb begin
    s0.active = b_run && (h < H_AREA_C) && (v < V_AREA_C);
    s0.hs     = b_run && (h >= HS_BEG) && (h < HS_END);
    s0.vs     = b_run && (v >= VS_BEG) && (v < VS_END);
  end

  assign oRD_ENA  = s0.active;
  assign oRD_SYNC = !b_run || ((h == H_LAST) && (v == V_LAST));

  // ---------------------------------------------------------------------------
  // S1: one stage of delay so timing matches the returned pixel
  // ---------------------------------------------------------------------------
`ifdef GCI_STD_DISP_TEST_PATTERN_EN
  cnt_t s1_h;
`endif

  always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      s1   <= '0;
`ifdef GCI_STD_DISP_TEST_PATTERN_EN
      s1_h <= '0;
`endif
    end else begin
      s1   <= s0;
`ifdef GCI_STD_DISP_TEST_PATTERN_EN
      s1_h <= h;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel select and underflow detect
  // ---------------------------------------------------------------------------
  assign rd_pix = '{r: iRD_DATA_R, g: iRD_DATA_G, b: iRD_DATA_B};

`ifdef GCI_STD_DISP_TEST_PATTERN_EN
  localparam cnt_t BAR_W = cnt_t'(P_H_AREA / 8);

  logic [2:0] bar;
  rgb_t       bar_pix;

  // Bar index past the visible area is garbage but never shown (active = 0).
  always_comb begin
    bar = 3'(s1_h / BAR_W);
    case (bar)
      3'd0:    bar_pix = 24'hFFFFFF;
      3'd1:    bar_pix = 24'hFFFF00;
      3'd2:    bar_pix = 24'h00FFFF;
      3'd3:    bar_pix = 24'h00FF00;
      3'd4:    bar_pix = 24'hFF00FF;
      3'd5:    bar_pix = 24'hFF0000;
      3'd6:    bar_pix = 24'h0000FF;
      default: bar_pix = 24'h000000;
    endcase
  end
`endif

  always_comb begin
    pix_next = (s1.active && iRD_VALID) ? rd_pix : '0;
    uf_evt   = s1.active && !iRD_VALID;
`ifdef GCI_STD_DISP_TEST_PATTERN_EN
    if (iPATTERN_SEL) begin
      pix_next = s1.active ? bar_pix : '0;
      uf_evt   = 1'b0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output registers. Loading blank while stopped means a mid-frame disable
  // is fully blanked two clocks after iDISP_ENA falls, and clears the sticky
  // underflow at the same time.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oDISP_DE    <= 1'b0;
      oDISP_HSYNC <= ~P_H_SYNC_POL;
      oDISP_VSYNC <= ~P_V_SYNC_POL;
      oDISP_R     <= '0;
      oDISP_G     <= '0;
      oDISP_B     <= '0;
      oUNDERFLOW  <= 1'b0;
    end else if (!b_run) begin
      oDISP_DE    <= 1'b0;
      oDISP_HSYNC <= ~P_H_SYNC_POL;
      oDISP_VSYNC <= ~P_V_SYNC_POL;
      oDISP_R     <= '0;
      oDISP_G     <= '0;
      oDISP_B     <= '0;
      oUNDERFLOW  <= 1'b0;
    end else begin
      oDISP_DE    <= s1.active;
      oDISP_HSYNC <= s1.hs ? P_H_SYNC_POL : ~P_H_SYNC_POL;
      oDISP_VSYNC <= s1.vs ? P_V_SYNC_POL : ~P_V_SYNC_POL;
      oDISP_R     <= pix_next.r;
      oDISP_G     <= pix_next.g;
      oDISP_B     <= pix_next.b;
      oUNDERFLOW  <= oUNDERFLOW | uf_evt;
    end
  end

endmodule

// File: tb/tb_gci_std_display_timing_out.sv
// Directed bench for gci_std_display_timing_out on a shrunken raster
// (24 x 8 total, 16 x 4 visible) so whole frames fit in a short run.
module tb_gci_std_display_timing_out;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = 24;
  localparam int VA = 4,  VF = 1, VS = 2, VB = 1, VT = 8;
  localparam int FRAME = HT * VT;  // 192

  logic       clk = 1'b0;
  logic       rst_n, ena, rd_ena, rd_sync, rd_valid;
  logic [7:0] rd_r, rd_g, rd_b;
  logic       hsync, vsync, de, uf;
  logic [7:0] r, g, b;
  logic       pat_sel;

  int checks = 0;
  int errors = 0;
  logic drop_next = 1'b0;
  logic no_valid  = 1'b0;
  int de_cnt, hs_cnt, vs_cnt, sync_cnt;

  always #5 clk = ~clk;

  gci_std_display_timing_out #(
    .P_H_AREA(HA), .P_H_FRONT(HF), .P_H_SYNC(HS), .P_H_BACK(HB),
    .P_V_AREA(VA), .P_V_FRONT(VF), .P_V_SYNC(VS), .P_V_BACK(VB),
    .P_H_SYNC_POL(1'b0), .P_V_SYNC_POL(1'b0), .P_CNT_N(10)
  ) dut (
    .iDISP_CLOCK(clk),
    .inRESET(rst_n),
    .iDISP_ENA(ena),
    .oRD_ENA(rd_ena),
    .oRD_SYNC(rd_sync),
    .iRD_VALID(rd_valid),
    .iRD_DATA_R(rd_r),
    .iRD_DATA_G(rd_g),
    .iRD_DATA_B(rd_b),
`ifdef GCI_STD_DISP_TEST_PATTERN_EN
    .iPATTERN_SEL(pat_sel),
`endif
    .oDISP_HSYNC(hsync),
    .oDISP_VSYNC(vsync),
    .oDISP_DE(de),
    .oDISP_R(r),
    .oDISP_G(g),
    .oDISP_B(b),
    .oUNDERFLOW(uf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int i);
    case (i)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // One clock. Models the read stage: valid/data follow oRD_ENA by one clock.
  task automatic tick();
    logic e;
    e = rd_ena;
    @(posedge clk);
    #1;
    rd_valid = e && !drop_next && !no_valid;
    {rd_r, rd_g, rd_b} = rd_valid ? {8'd12, 8'd34, 8'd56} : 24'hEEEEEE;
    if (de) de_cnt++;
    if (!hsync) hs_cnt++;
    if (!vsync) vs_cnt++;
    if (rd_sync) sync_cnt++;
  endtask

  // k = 0 is the first edge that samples iDISP_ENA = 1. Request side shows
  // raster position k, panel side shows position k-2.
  task automatic run(input int n, input int uf_pos, input bit pat);
    for (int k = 0; k < n; k++) begin
      int hk, vk, p, hp, vp;
      logic exp_de;
      logic [23:0] exp_rgb;
      drop_next = (uf_pos >= 0) && (k == uf_pos + 1);
      tick();
      hk = k % HT;
      vk = (k / HT) % VT;
      chk("rd_ena", 32'(rd_ena), 32'(hk < HA && vk < VA));
      chk("rd_sync", 32'(rd_sync), 32'(k % FRAME == FRAME - 1));
      if (k >= 2) begin
        p  = k - 2;
        hp = p % HT;
        vp = (p / HT) % VT;
        exp_de = (hp < HA) && (vp < VA);
        if (!exp_de)          exp_rgb = 24'h0;
        else if (pat)         exp_rgb = bar_rgb(hp / (HA / 8));
        else if (p == uf_pos) exp_rgb = 24'h0;
        else                  exp_rgb = 24'h0C2238;
        chk("de", 32'(de), 32'(exp_de));
        chk("hsync", 32'(hsync), 32'(!(hp >= HA + HF && hp < HA + HF + HS)));
        chk("vsync", 32'(vsync), 32'(!(vp >= VA + VF && vp < VA + VF + VS)));
        chk("rgb", 32'({r, g, b}), 32'(exp_rgb));
        chk("underflow", 32'(uf), 32'(uf_pos >= 0 && p >= uf_pos));
      end else begin
        chk("de_fill", 32'(de), 32'd0);
        chk("rgb_fill", 32'({r, g, b}), 32'd0);
      end
    end
    drop_next = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; pat_sel = 1'b0;
    rd_valid = 1'b0; rd_r = '0; rd_g = '0; rd_b = '0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; sync_cnt = 0;
    #12;
    chk("rst_rd_ena", 32'(rd_ena), 32'd0);
    chk("rst_rd_sync", 32'(rd_sync), 32'd1);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    chk("rst_uf", 32'(uf), 32'd0);
    rst_n = 1'b1;

    // Stopped: no requests, read stage held in resync, blanked
    repeat (5) begin
      tick();
      chk("idle_rd_ena", 32'(rd_ena), 32'd0);
      chk("idle_rd_sync", 32'(rd_sync), 32'd1);
      chk("idle_de", 32'(de), 32'd0);
    end

    // Enable: first request one clock later. Run past one frame; one invalid
    // pixel at position 221 (frame 2, line 1, pixel 5).
    ena = 1'b1;
    chk("pre_rd_ena", 32'(rd_ena), 32'd0);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; sync_cnt = 0;
    run(FRAME + 2 * HT + 10, FRAME + HT + 5, 1'b0);
    chk("de_count", 32'(de_cnt), 32'd104);
    chk("hs_count", 32'(hs_cnt), 32'd30);
    chk("vs_count", 32'(vs_cnt), 32'd48);
    chk("sync_pulses", 32'(sync_cnt), 32'd1);

    // Drop enable mid-line while DE is high and underflow is set
    ena = 1'b0;
    tick();
    chk("off_rd_ena", 32'(rd_ena), 32'd0);
    chk("off_rd_sync", 32'(rd_sync), 32'd1);
    tick();
    chk("off_de", 32'(de), 32'd0);
    chk("off_rgb", 32'({r, g, b}), 32'd0);
    chk("off_uf", 32'(uf), 32'd0);
    chk("off_hsync", 32'(hsync), 32'd1);

    // Re-enable: raster restarts at 0,0
    ena = 1'b1;
    run(HT + 4, -1, 1'b0);

`ifdef GCI_STD_DISP_TEST_PATTERN_EN
    // Colour bars with the read path returning nothing valid
    ena = 1'b0;
    tick();
    tick();
    pat_sel = 1'b1;
    no_valid = 1'b1;
    ena = 1'b1;
    run(HT + 4, -1, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
